// File: rtl/gray_conv_arbiter_if.sv
// Handshake bundle for the two-requester Gray/binary converter: two operand
// channels in, one result channel out, plus the completed-transfer counter.
interface gray_conv_arbiter_if #(
  parameter int W = 3
) ();
  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_mode;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_mode;
  logic         req1_ready;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         res_ready;
  logic [7:0]   xfer_cnt;

  modport master (
    output req0_valid, req0_data, req0_mode,
    input  req0_ready,
    output req1_valid, req1_data, req1_mode,
    input  req1_ready,
    input  res_valid, res_data, res_id, xfer_cnt,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_mode,
    output req0_ready,
    input  req1_valid, req1_data, req1_mode,
    output req1_ready,
    output res_valid, res_data, res_id, xfer_cnt,
    input  res_ready
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter between two requesters feeding a one-entry result register
// that holds a binary->Gray or Gray->binary conversion of the granted operand.
module gray_conv_arbiter #(
  parameter int W = 3
) (
  input logic             clk,
  input logic             rst_n,
  gray_conv_arbiter_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]   state_r;
  logic [W-1:0] res_data_r;
  logic         res_id_r;
  logic         last_grant_r;
  logic [7:0]   xfer_cnt_r;

  logic         res_valid_s;
  logic         can_accept_s;
  logic         accept_s;
  logic         grant_id_s;
  logic [W-1:0] grant_data_s;
  logic         grant_mode_s;
  logic         xfer_s;

  function automatic logic [W-1:0] bin_to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit depends on the one above it, so resolve from the MSB down.
  function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [W-1:0] convert(input logic [W-1:0] d, input logic mode);
    if (mode) begin
      return gray_to_bin(d);
    end else begin
      return bin_to_gray(d);
    end
  endfunction

  assign res_valid_s = (state_r == ST_FULL);
  assign xfer_s      = res_valid_s && bus.res_ready;

  // Grant selection; on a tie the requester that did not win last time goes first.
  always_comb begin
    grant_id_s   = 1'b0;
    can_accept_s = !res_valid_s || bus.res_ready;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_s = ~last_grant_r;
    end else if (bus.req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    accept_s = rst_n && can_accept_s && (bus.req0_valid || bus.req1_valid);
    if (grant_id_s) begin
      grant_data_s = bus.req1_data;
      grant_mode_s = bus.req1_mode;
    end else begin
      grant_data_s = bus.req0_data;
      grant_mode_s = bus.req0_mode;
    end
  end

  assign bus.req0_ready = accept_s && !grant_id_s;
  assign bus.req1_ready = accept_s && grant_id_s;

  // Result register occupancy: a new acceptance always refills, a drain empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) state_r <= ST_FULL;
          else          state_r <= ST_EMPTY;
        end
        ST_FULL: begin
          if (accept_s)           state_r <= ST_FULL;
          else if (bus.res_ready) state_r <= ST_EMPTY;
          else                    state_r <= ST_FULL;
        end
        default: state_r <= ST_EMPTY;
      endcase
    end
  end

  // Result payload and round-robin pointer, both updated only on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data_r   <= {W{1'b0}};
      res_id_r     <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      res_data_r   <= convert(grant_data_s, grant_mode_s);
      res_id_r     <= grant_id_s;
      last_grant_r <= grant_id_s;
    end
  end

  // Completed result handshakes, free-running modulo 256.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_r <= 8'd0;
    end else if (xfer_s) begin
      xfer_cnt_r <= xfer_cnt_r + 8'd1;
    end
  end

  assign bus.res_valid = res_valid_s;
  assign bus.res_data  = res_data_r;
  assign bus.res_id    = res_id_r;
  assign bus.xfer_cnt  = xfer_cnt_r;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: the driver predicts grants and pushes
// expected results; a separate monitor checks each presented result and the counter.
module tb_gray_conv_arbiter;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_conv_arbiter_if #(.W(W)) bus ();

  gray_conv_arbiter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [W:0] exp_q[$];
  logic [2:0] b2g_tab[8];
  logic [2:0] g2b_tab[8];
  logic       m_full;
  logic       m_last;
  logic [7:0] exp_cnt;
  bit         done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] lookup(input logic [2:0] d, input logic m);
    if (m) return g2b_tab[d];
    else   return b2g_tab[d];
  endfunction

  task automatic cycle(input logic rn,
                       input logic v0, input logic [2:0] d0, input logic m0,
                       input logic v1, input logic [2:0] d1, input logic m1,
                       input logic rr);
    logic acc;
    logic gnt;
    @(negedge clk);
    rst_n          = rn;
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req0_mode  = m0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.req1_mode  = m1;
    bus.res_ready  = rr;
    #1;
    acc = rn && (!m_full || rr) && (v0 || v1);
    gnt = (v0 && v1) ? ~m_last : v1;
    check("req0_ready", 32'(bus.req0_ready), 32'(acc && !gnt));
    check("req1_ready", 32'(bus.req1_ready), 32'(acc && gnt));
    check("res_valid_state", 32'(bus.res_valid), 32'(m_full));
    if (acc) begin
      if (gnt) exp_q.push_back({1'b1, lookup(d1, m1)});
      else     exp_q.push_back({1'b0, lookup(d0, m0)});
    end
    @(posedge clk);
    if (!rn) begin
      m_full = 1'b0;
      m_last = 1'b1;
    end else if (acc) begin
      m_full = 1'b1;
      m_last = gnt;
    end else if (m_full && rr) begin
      m_full = 1'b0;
    end
  endtask

  // Monitor: checks the counter every cycle and any presented result against the queue head.
  initial begin
    exp_cnt = 8'd0;
    forever begin
      @(negedge clk);
      #2;
      if (done) break;
      check("xfer_cnt", 32'(bus.xfer_cnt), 32'(exp_cnt));
      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          check("res_valid_spurious", 32'(bus.res_valid), 32'd0);
        end else begin
          check("res_data", 32'(bus.res_data), 32'(exp_q[0][W-1:0]));
          check("res_id", 32'(bus.res_id), 32'(exp_q[0][W]));
        end
      end
      if (!rst_n) begin
        exp_q.delete();
        exp_cnt = 8'd0;
      end else if (bus.res_valid && bus.res_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  initial begin
    b2g_tab[0] = 3'd0; b2g_tab[1] = 3'd1; b2g_tab[2] = 3'd3; b2g_tab[3] = 3'd2;
    b2g_tab[4] = 3'd6; b2g_tab[5] = 3'd7; b2g_tab[6] = 3'd5; b2g_tab[7] = 3'd4;
    g2b_tab[0] = 3'd0; g2b_tab[1] = 3'd1; g2b_tab[2] = 3'd3; g2b_tab[3] = 3'd2;
    g2b_tab[4] = 3'd7; g2b_tab[5] = 3'd6; g2b_tab[6] = 3'd4; g2b_tab[7] = 3'd5;
    m_full = 1'b0;
    m_last = 1'b1;
    done   = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = 3'd0; bus.req0_mode = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = 3'd0; bus.req1_mode = 1'b0;
    bus.res_ready  = 1'b0;

    // Reset with both requesters asserting: no ready may rise.
    cycle(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    #1;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_id", 32'(bus.res_id), 32'd0);
    check("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);

    // Single requests: 101 -> Gray 111, then Gray 111 -> binary 101 back-to-back.
    cycle(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    // Continuous tie: grants alternate.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 3'd6, 1'b1, 1'b1);

    // Back-pressure for 5 cycles with both requesters pending, then drain once.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    // Fill, hold while FULL, reset, then the first tie must go to requester 0.
    cycle(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    check("rst_full_valid", 32'(bus.res_valid), 32'd0);
    check("rst_full_cnt", 32'(bus.xfer_cnt), 32'd0);

    // Code sweep in both modes with back-to-back ties, long enough to wrap the counter.
    for (int i = 0; i < 272; i++) begin
      logic [2:0] d0;
      logic [2:0] d1;
      logic       m0;
      d0 = 3'((i / 2) % 8);
      d1 = 3'(((i / 2) + 3) % 8);
      m0 = 1'((i / 16) % 2);
      cycle(1'b1, 1'b1, d0, m0, 1'b1, d1, ~m0, 1'b1);
    end
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    done = 1'b1;
    @(negedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
